equiv_sweep_ctrl: RTL and testbench
===================================

Name: equiv_sweep_ctrl

Overview:
- Sequencer that drives every input combination onto two combinational implementations of the same function (POS reference vs. SOP candidate) and compares their outputs.
- Replaces hand-written stimulus sweeps. It counts mismatches, records the first failing vector, and reports pass/fail with a start/done handshake.
- Sits between a bench or top-level and the two function instances. Its `abc` output fans out to both instances; their outputs return on `m_q` and `m_a`.

Parameters:
- N_IN, 3: width of the input vector swept; vectors 0 .. 2^N_IN-1.
- SETTLE_CYCLES, 1: cycles a vector is held before outputs are sampled. Legal range is >=1; values <1 are illegal.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin sweep; accepted only in IDLE.
- abort  input  1  synchronous abort of a running sweep.
- m_q  input  1  output of reference (POS) implementation.
- m_a  input  1  output of candidate (SOP) implementation.
- abc  output  N_IN  vector applied to both implementations; MSB = a.
- busy  output  1  high in SETTLE/CHECK.
- done  output  1  one-cycle pulse on sweep completion.
- pass  output  1  1 when last completed sweep had zero mismatches.
- err_cnt  output  N_IN+1  mismatch count for current/last sweep.
- err_valid  output  1  at least one mismatch recorded.
- first_err_vec  output  N_IN  vector of first mismatch; valid when err_valid.

Behaviour:
- Reset (async, rst_n=0), all outputs 0:
  - state=IDLE, abc=0, busy=0, done=0, pass=0, err_cnt=0, err_valid=0, first_err_vec=0, settle counter=0.
  - Reset mid-sweep aborts immediately with no done.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - abc held 0.
  - start=1 at an edge: go to SETTLE, abc=0, cnt=0. Same edge clears err_cnt, err_valid, first_err_vec and pass.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to CHECK on the next edge.
- CHECK:
  - At the edge leaving CHECK, compare m_q vs m_a.
  - On mismatch: err_cnt+1. If err_valid=0, also capture first_err_vec=abc and set err_valid=1.
  - If abc==2^N_IN-1, go to DONE. Otherwise abc+1, cnt=0, go to SETTLE.
- DONE:
  - One cycle: done=1, pass=(err_cnt==0), busy=0.
  - Next edge goes to IDLE and abc returns to 0.
  - pass, err_cnt, err_valid and first_err_vec hold until the next accepted start.
- Timing:
  - Each vector occupies exactly SETTLE_CYCLES+1 cycles.
  - done is high 2^N_IN*(SETTLE_CYCLES+1) edges after the start edge; default 16.
- start while busy or in DONE is ignored (no restart, no counter change).
- abort=1 in SETTLE/CHECK:
  - Next state IDLE, abc=0, busy=0, done stays 0, pass=0.
  - err_cnt, err_valid and first_err_vec keep their partial values.
  - abort has priority over the CHECK compare in the same cycle, so that comparison is discarded.
  - abort in IDLE/DONE has no effect.
- err_cnt width N_IN+1 holds the full count 2^N_IN without wrap. abc increments never wrap, because the last vector exits to DONE.
- m_q/m_a are combinational from abc; sampling only in CHECK guarantees at least SETTLE_CYCLES of hold time.

Test Plan:
- Equivalent pair (m_a=m_q for all 8 vectors), start pulse:
  - abc steps 0..7, each held 2 cycles.
  - done pulses 16 cycles after start, with pass=1, err_cnt=0, err_valid=0.
- Candidate wrong only at abc=5:
  - done with pass=0, err_cnt=1, err_valid=1, first_err_vec=5.
- Mismatches at abc=2 and 7:
  - err_cnt=2, first_err_vec=2 (not overwritten by 7).
- Candidate = ~reference:
  - err_cnt=8 (4'b1000, no wrap), first_err_vec=0, pass=0.
- start pulsed at abc=4 during sweep:
  - Ignored; sweep continues to 7 and done still at cycle 16.
- abort pulsed in CHECK at abc=3:
  - Next cycle IDLE, busy=0, abc=0, no done, and that compare is not counted.
  - A following start restarts at abc=0 with err_cnt cleared.
- rst_n dropped asynchronously at abc=6:
  - All outputs 0 immediately, with no clock edge needed.
  - After release, start produces a full 16-cycle sweep.

Source files
------------

// File: rtl/equiv_sweep_ctrl.sv
// equiv_sweep_ctrl
//   Drives every N_IN-bit input combination onto a reference (POS) and a
//   candidate (SOP) implementation of the same function. It compares their
//   outputs and reports the result through a start/done handshake.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a sweep (accepted only while idle)
//   abort         abandon a running sweep (no done pulse)
//   m_q           reference implementation output
//   m_a           candidate implementation output
//   abc           vector applied to both implementations, MSB = a
//   busy          sweep in progress (SETTLE/CHECK)
//   done          one-cycle completion pulse
//   pass          last completed sweep had no mismatches
//   err_cnt       mismatch count of the current/last sweep
//   err_valid     at least one mismatch recorded
//   first_err_vec vector of the first mismatch (valid with err_valid)
module equiv_sweep_ctrl #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            m_q,
  input  logic            m_a,
  output logic [N_IN-1:0] abc,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            err_valid,
  output logic [N_IN-1:0] first_err_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [N_IN-1:0]  LAST_VEC = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_IN-1:0]  abc_nxt;
  logic [N_IN-1:0]  first_err_vec_nxt;
  logic [N_IN:0]    err_cnt_nxt;
  logic             err_valid_nxt;
  logic             pass_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      abc           <= '0;
      err_cnt       <= '0;
      err_valid     <= 1'b0;
      first_err_vec <= '0;
      pass          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      abc           <= abc_nxt;
      err_cnt       <= err_cnt_nxt;
      err_valid     <= err_valid_nxt;
      first_err_vec <= first_err_vec_nxt;
      pass          <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    abc_nxt           = abc;
    err_cnt_nxt       = err_cnt;
    err_valid_nxt     = err_valid;
    first_err_vec_nxt = first_err_vec;
    pass_nxt          = pass;

    case (state)
      S_IDLE: begin
        abc_nxt = '0;
        cnt_nxt = '0;
        if (start) begin
          state_nxt         = S_SETTLE;
          err_cnt_nxt       = '0;
          err_valid_nxt     = 1'b0;
          first_err_vec_nxt = '0;
          pass_nxt          = 1'b0;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_nxt = S_IDLE;
          abc_nxt   = '0;
          cnt_nxt   = '0;
          pass_nxt  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_CHECK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_CHECK: begin
        // abort wins over the compare: the vector under test is not scored
        if (abort) begin
          state_nxt = S_IDLE;
          abc_nxt   = '0;
          cnt_nxt   = '0;
          pass_nxt  = 1'b0;
        end else begin
          if (m_q != m_a) begin
            err_cnt_nxt = err_cnt + (N_IN + 1)'(1);
            if (!err_valid) begin
              err_valid_nxt     = 1'b1;
              first_err_vec_nxt = abc;
            end
          end
          if (abc == LAST_VEC) begin
            // abc stays on the last vector; no increment, so it never wraps
            state_nxt = S_DONE;
            pass_nxt  = (err_cnt_nxt == '0);
          end else begin
            state_nxt = S_SETTLE;
            abc_nxt   = abc + N_IN'(1);
            cnt_nxt   = '0;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        abc_nxt   = '0;
        cnt_nxt   = '0;
      end

      default: begin
        state_nxt = S_IDLE;
        abc_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
module tb_equiv_sweep_ctrl;

  localparam int N   = 3;
  localparam int S   = 1;
  localparam int NV  = 1 << N;
  localparam int VC  = S + 1;
  localparam int TOT = NV * VC;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NV-1:0] tt_q  = '0;
  logic [NV-1:0] tt_a  = '0;
  logic          m_q, m_a;
  logic [N-1:0]  abc;
  logic          busy, done, pass, err_valid;
  logic [N:0]    err_cnt;
  logic [N-1:0]  first_err_vec;

  int total = 0;
  int bad   = 0;

  // the two "implementations" are truth tables looked up by abc
  assign m_q = tt_q[abc];
  assign m_a = tt_a[abc];

  always #5 clk = ~clk;

  equiv_sweep_ctrl #(.N_IN(N), .SETTLE_CYCLES(S)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .m_q           (m_q),
    .m_a           (m_a),
    .abc           (abc),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .err_valid     (err_valid),
    .first_err_vec (first_err_vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // number of mismatching vectors with index below k
  function automatic int n_below(input logic [NV-1:0] mm, input int k);
    int n = 0;
    for (int i = 0; i < NV; i++)
      if (i < k && mm[i]) n++;
    return n;
  endfunction

  function automatic int first_idx(input logic [NV-1:0] mm);
    for (int i = 0; i < NV; i++)
      if (mm[i]) return i;
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_abc"}, 32'(abc), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    chk({tag, "_err_valid"}, 32'(err_valid), 0);
    chk({tag, "_first"}, 32'(first_err_vec), 0);
  endtask

  // Full sweep with cycle-by-cycle expectations; optional start pulse at abc=4
  task automatic sweep(input logic [NV-1:0] tq, input logic [NV-1:0] ta, input bit glitch);
    logic [NV-1:0] mm;
    int            nerr;
    tt_q = tq;
    tt_a = ta;
    mm   = tq ^ ta;
    nerr = n_below(mm, NV);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_abc", 32'(abc), 0);
    chk("start_busy", 32'(busy), 1);
    chk("start_err_cnt", 32'(err_cnt), 0);
    chk("start_err_valid", 32'(err_valid), 0);
    for (int j = 1; j <= TOT; j++) begin
      if (glitch && (j - 1) == 4 * VC) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (j < TOT) begin
        chk("run_abc", 32'(abc), 32'(j / VC));
        chk("run_busy", 32'(busy), 1);
        chk("run_done", 32'(done), 0);
        chk("run_err_cnt", 32'(err_cnt), 32'(n_below(mm, j / VC)));
      end else begin
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_pass", 32'(pass), (nerr == 0) ? 1 : 0);
        chk("done_err_cnt", 32'(err_cnt), 32'(nerr));
        chk("done_err_valid", 32'(err_valid), (nerr != 0) ? 1 : 0);
        chk("done_first", 32'(first_err_vec), 32'(first_idx(mm)));
      end
    end
    @(posedge clk);
    #1;
    chk("post_done", 32'(done), 0);
    chk("post_abc", 32'(abc), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_pass", 32'(pass), (nerr == 0) ? 1 : 0);
    chk("post_err_cnt", 32'(err_cnt), 32'(nerr));
  endtask

  initial begin
    logic [NV-1:0] r;
    logic [NV-1:0] mm;

    // reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 0);

    // abort while idle does nothing
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_done", 32'(done), 0);

    // directed pairs
    r = NV'($urandom);
    sweep(r, r, 1'b0);                          // equivalent
    sweep(r, r ^ NV'(8'h20), 1'b0);             // wrong only at 5
    sweep(r, r ^ NV'(8'h84), 1'b0);             // wrong at 2 and 7
    sweep(r, ~r, 1'b0);                         // all wrong: count 8
    sweep(r, r ^ NV'(8'h10), 1'b1);             // start pulsed at abc=4

    // randomized pairs
    for (int k = 0; k < 6; k++) sweep(NV'($urandom), NV'($urandom), 1'b0);

    // abort in CHECK at abc=3 (mismatches at 1 and 3; 3 must not count)
    r    = NV'($urandom);
    tt_q = r;
    tt_a = r ^ NV'(8'h0A);
    mm   = NV'(8'h0A);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 1; j <= 3 * VC + S; j++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_pre_abc", 32'(abc), 3);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_abc", 32'(abc), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_pass", 32'(pass), 0);
    chk("abort_err_cnt", 32'(err_cnt), 32'(n_below(mm, 3)));
    chk("abort_err_valid", 32'(err_valid), 1);
    chk("abort_first", 32'(first_err_vec), 1);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done), 0);
    end
    sweep(r, r, 1'b0);

    // asynchronous reset mid-sweep at abc=6
    tt_q = r;
    tt_a = r ^ NV'(8'h01);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 1; j <= 6 * VC; j++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_pre_abc", 32'(abc), 6);
    chk("rst_pre_err_cnt", 32'(err_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    chk("rst_hold_done", 32'(done), 0);
    rst_n = 1'b1;
    sweep(r, r ^ NV'(8'h40), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
